// File: rtl/sm_mul_arbiter.sv
// Round-robin front end that shares one sequential (SM) multiplier among
// several requesters and returns tagged products, with a timeout guard.
module sm_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     rsp_error,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_ready
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               start_q, start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;
    logic               rsp_err_q, rsp_err_d;

    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    cand;
    logic               grant_found;
    logic               accept;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];

    // Index arithmetic modulo NUM_REQ; works for non-power-of-two counts.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base,
                                                 input int unsigned step);
        int unsigned sum;
        sum = 32'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Split the packed operand buses into per-requester words.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin search starting at rr_ptr for the first valid requester.
    always_comb begin
        grant       = '0;
        cand        = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = wrap_inc(rr_ptr_q, k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_found && !reset;

    // Ready is offered only to the granted requester, only while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Next-state and datapath-update logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opa_d    = a_arr[grant];
                    opb_d    = b_arr[grant];
                    cur_id_d = grant;
                    start_d  = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                // Skip one cycle so a ready left high by the prior op is not taken.
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_ready) begin
                    rsp_prod_d  = mul_product;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_prod_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = wrap_inc(cur_id_q, 1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mul_start        = start_q;
    assign mul_multiplicand = opa_q;
    assign mul_multiplier   = opb_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_product      = rsp_prod_q;
    assign rsp_error        = rsp_err_q;

endmodule

// File: tb/tb_sm_mul_arbiter.sv
// Testbench for sm_mul_arbiter: vector table, corner-case sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_sm_mul_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             rsp_error;
    logic             mul_start;
    logic [W-1:0]     mul_multiplicand;
    logic [W-1:0]     mul_multiplier;
    logic [2*W-1:0]   mul_product = '0;
    logic             mul_ready = 1'b0;

    sm_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(64), .ID_W(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_error(rsp_error),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_product(mul_product),
        .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- multiplier model ----------------
    int         sm_lat = 5;
    bit         sm_never = 1'b0;
    bit         sm_stale = 1'b0;
    logic [W-1:0] sm_a = '0, sm_b = '0;
    int         sm_cnt = 0;
    bit         sm_busy = 1'b0;
    bit         drop_pend = 1'b0;

    // Ready stays high after completion until the next start; stale mode
    // keeps it high for one extra cycle after the start pulse.
    always @(posedge clk) begin
        if (mul_start) begin
            sm_a    <= mul_multiplicand;
            sm_b    <= mul_multiplier;
            sm_cnt  <= sm_lat;
            sm_busy <= 1'b1;
            if (sm_stale) drop_pend <= 1'b1;
            else          mul_ready <= 1'b0;
        end else begin
            if (drop_pend) begin
                mul_ready <= 1'b0;
                drop_pend <= 1'b0;
            end
            if (sm_busy && !sm_never) begin
                if (sm_cnt <= 1) begin
                    mul_ready   <= 1'b1;
                    mul_product <= {16'b0, sm_a} * {16'b0, sm_b};
                    sm_busy     <= 1'b0;
                end else begin
                    sm_cnt <= sm_cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;

    exp_t         expq[$];
    int           grant_log[$];
    int           mptr = 0;
    bit           outstanding = 1'b0;
    logic [N-1:0] hs_last = '0;
    logic [N-1:0] exp_ready;
    bit           hold_pend = 1'b0;
    logic [IDW-1:0] hold_id;
    logic [2*W-1:0] hold_prod;
    logic         hold_err;
    int           n_starts = 0;
    int           n_rdy = 0;
    exp_t         e;

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            mptr        = 0;
            outstanding = 1'b0;
            hold_pend   = 1'b0;
            hs_last     = '0;
            check("reset_req_ready", 64'(req_ready), 64'(0));
        end else begin
            exp_ready = '0;
            if (!outstanding) begin
                for (int k = 0; k < N; k++) begin
                    if (exp_ready == '0 && req_valid[(mptr + k) % N]) exp_ready[(mptr + k) % N] = 1'b1;
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            if (mul_start) n_starts++;
            if (|req_ready) n_rdy++;
            hs_last = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (hs_last[i]) begin
                    e.id = IDW'(i);
                    if (sm_never) begin
                        e.prod = '0;
                        e.err  = 1'b1;
                    end else begin
                        e.prod = {16'b0, req_a[i*W +: W]} * {16'b0, req_b[i*W +: W]};
                        e.err  = 1'b0;
                    end
                    expq.push_back(e);
                    grant_log.push_back(i);
                    outstanding = 1'b1;
                end
            end
            if (hold_pend) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'(1));
                check("rsp_hold_id", 64'(rsp_id), 64'(hold_id));
                check("rsp_hold_prod", 64'(rsp_product), 64'(hold_prod));
                check("rsp_hold_err", 64'(rsp_error), 64'(hold_err));
            end
            hold_pend = 1'b0;
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else if (rsp_ready) begin
                    e = expq.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_product", 64'(rsp_product), 64'(e.prod));
                    check("rsp_error", 64'(rsp_error), 64'(e.err));
                    mptr        = (int'(e.id) + 1) % N;
                    outstanding = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    hold_id   = rsp_id;
                    hold_prod = rsp_product;
                    hold_err  = rsp_error;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int auto_mode = 0;  // 0: one-shot requests, 1: random traffic, 2: all always valid

    function automatic logic [W-1:0] rand_op();
        if ($urandom_range(0, 3) == 0) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    task automatic load_ops(input int i);
        req_a[i*W +: W] = rand_op();
        req_b[i*W +: W] = rand_op();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            case (auto_mode)
                0: if (hs_last[i]) req_valid[i] = 1'b0;
                1: begin
                    if (hs_last[i]) begin
                        if ($urandom_range(0, 1) == 1) load_ops(i);
                        else req_valid[i] = 1'b0;
                    end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        load_ops(i);
                        req_valid[i] = 1'b1;
                    end
                end
                default: if (hs_last[i]) load_ops(i);
            endcase
        end
        if (auto_mode == 1) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            sm_lat    = $urandom_range(2, 20);
        end
    endtask

    task automatic wait_rsp(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("rsp_wait_timeout", 64'(rsp_valid), 64'(1));
    endtask

    task automatic drain(input int max);
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (expq.size() == 0 && !outstanding && req_valid == '0) break;
            tick();
        end
        check("drain_idle", 64'({req_valid, outstanding}), 64'(0));
        check("drain_queue", 64'(expq.size()), 64'(0));
        tick();
    endtask

    task automatic run_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [IDW-1:0] gid, output logic [2*W-1:0] gprod,
                              output logic gerr, output int starts, output int rdys);
        int s0, r0;
        bit ok;
        s0 = n_starts;
        r0 = n_rdy;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        wait_rsp(300, ok);
        gid    = rsp_id;
        gprod  = rsp_product;
        gerr   = rsp_error;
        starts = n_starts - s0;
        rdys   = n_rdy - r0;
        tick();
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vt[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IDW-1:0] gid, bid;
        logic [2*W-1:0] gprod, bprod;
        logic gerr, berr;
        int starts, rdys, g0, t_start, t_rsp;
        bit ok;

        vt[0] = '{2, 16'h0003, 16'h0005, 17, 32'h0000000F};
        vt[1] = '{0, 16'hFFFF, 16'hFFFF,  3, 32'hFFFE0001};
        vt[2] = '{1, 16'h0000, 16'h1234,  2, 32'h00000000};
        vt[3] = '{3, 16'h1234, 16'h0010,  8, 32'h00012340};
        vt[4] = '{2, 16'h8000, 16'h0002,  5, 32'h00010000};
        vt[5] = '{1, 16'h00FF, 16'h0100, 40, 32'h0000FF00};

        reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #1 reset = 1'b1;
        req_a = {16'h0010, 16'h0003, 16'h0001, 16'hFFFF};
        req_b = {16'h0010, 16'h0005, 16'h0002, 16'hFFFF};
        req_valid = '1;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mul_start", 64'(mul_start), 64'(0));
        check("rst_operands", 64'({mul_multiplicand, mul_multiplier}), 64'(0));

        // All requesters valid from reset: strict rotation.
        repeat (2) @(posedge clk);
        #1;
        grant_log.delete();
        sm_lat = 4;
        auto_mode = 2;
        reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant_log.size() >= 5) break;
            tick();
        end
        check("rr_grant_count", 64'(grant_log.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            check("rr_grant_order", 64'(grant_log.size() > i ? grant_log[i] : -1), 64'(i % N));
        end
        tick();
        auto_mode = 0;
        req_valid = '0;
        drain(200);

        // Vector table: isolated single requests.
        for (int i = 0; i < 6; i++) begin
            sm_lat = vt[i].lat;
            run_single(vt[i].id, vt[i].a, vt[i].b, gid, gprod, gerr, starts, rdys);
            check("vec_id", 64'(gid), 64'(vt[i].id));
            check("vec_product", 64'(gprod), 64'(vt[i].prod));
            check("vec_error", 64'(gerr), 64'(0));
            check("vec_start_pulses", 64'(starts), 64'(1));
            check("vec_ready_cycles", 64'(rdys), 64'(1));
        end

        // Backpressure: response held for 10 cycles, nothing else moves.
        sm_lat = 6;
        rsp_ready = 1'b0;
        req_a[2*W +: W] = 16'h1111;
        req_b[2*W +: W] = 16'h0003;
        req_valid[2] = 1'b1;
        wait_rsp(100, ok);
        bid = rsp_id; bprod = rsp_product; berr = rsp_error;
        check("bp_product", 64'(bprod), 64'(32'h00003333));
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) begin
                req_a[0 +: W] = 16'h0002; req_b[0 +: W] = 16'h0009; req_valid[0] = 1'b1;
                req_a[3*W +: W] = 16'h0007; req_b[3*W +: W] = 16'h0007; req_valid[3] = 1'b1;
            end
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_id", 64'(rsp_id), 64'(bid));
            check("bp_prod", 64'(rsp_product), 64'(bprod));
            check("bp_err", 64'(rsp_error), 64'(berr));
            check("bp_req_ready", 64'(req_ready), 64'(0));
            check("bp_mul_start", 64'(mul_start), 64'(0));
        end
        tick();
        rsp_ready = 1'b1;
        g0 = grant_log.size();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant_log.size() > g0) break;
            tick();
        end
        check("bp_next_grant", 64'(grant_log.size() > g0 ? grant_log[g0] : -1), 64'(3));
        tick();
        drain(300);

        // Stale ready from the previous op must be masked.
        sm_stale = 1'b1;
        sm_lat = 6;
        run_single(0, 16'h0007, 16'h0009, gid, gprod, gerr, starts, rdys);
        check("stale_product", 64'(gprod), 64'(32'h0000003F));
        check("stale_error", 64'(gerr), 64'(0));
        sm_stale = 1'b0;

        // Timeout: multiplier never completes.
        sm_never = 1'b1;
        req_a[1*W +: W] = 16'h0005; req_b[1*W +: W] = 16'h0006; req_valid[1] = 1'b1;
        t_start = -1; t_rsp = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mul_start && t_start < 0) t_start = c;
            if (rsp_valid) begin
                t_rsp = c;
                break;
            end
            tick();
        end
        check("timeout_latency", 64'(t_rsp - t_start), 64'(66));
        check("timeout_error", 64'(rsp_error), 64'(1));
        check("timeout_product", 64'(rsp_product), 64'(0));
        tick();
        sm_never = 1'b0;
        sm_lat = 5;
        run_single(2, 16'h0100, 16'h0100, gid, gprod, gerr, starts, rdys);
        check("post_timeout_product", 64'(gprod), 64'(32'h00010000));
        check("post_timeout_error", 64'(gerr), 64'(0));

        // Reset while waiting on the multiplier.
        sm_never = 1'b1;
        req_a[3*W +: W] = 16'h0ABC; req_b[3*W +: W] = 16'h0DEF; req_valid[3] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mul_start) break;
            tick();
        end
        tick(); tick(); tick();
        req_valid[0] = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        check("mid_rst_rsp_product", 64'(rsp_product), 64'(0));
        check("mid_rst_rsp_error", 64'(rsp_error), 64'(0));
        check("mid_rst_mul_start", 64'(mul_start), 64'(0));
        check("mid_rst_multiplicand", 64'(mul_multiplicand), 64'(0));
        check("mid_rst_multiplier", 64'(mul_multiplier), 64'(0));
        req_valid = '0;
        req_a[1*W +: W] = 16'h0002; req_b[1*W +: W] = 16'h0003; req_valid[1] = 1'b1;
        req_a[3*W +: W] = 16'h0004; req_b[3*W +: W] = 16'h0005; req_valid[3] = 1'b1;
        sm_never = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        g0 = grant_log.size();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant_log.size() > g0) break;
            tick();
        end
        check("post_reset_grant", 64'(grant_log.size() > g0 ? grant_log[g0] : -1), 64'(1));
        tick();
        drain(300);

        // Randomized traffic with random backpressure and latency.
        auto_mode = 1;
        repeat (1500) tick();
        auto_mode = 0;
        rsp_ready = 1'b1;
        sm_lat = 4;
        drain(600);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm_mul_arbiter.md
Name: sm_mul_arbiter

Overview:
Round-robin arbiter/sequencer that shares one SM sequential multiplier among NUM_REQ requesters. Each requester has its own valid/ready request channel. The block accepts one operand pair at a time, pulses the multiplier start, and waits for multiplier completion under a timeout guard. It returns the product on a shared response channel tagged with the requester id. It sits between client blocks and the single SM instance; it does not drive the SM reset.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 16, operand width; product is 2*WIDTH
TIMEOUT, 64, max WAIT cycles before an error response (>=2)
ID_W, $clog2(NUM_REQ), response id width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*WIDTH  multiplicands; requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  multipliers; same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester index of the response
rsp_product  out  2*WIDTH  product
rsp_error  out  1  1 = timeout; product is 0
mul_start  out  1  one-cycle start pulse to SM
mul_multiplicand  out  WIDTH  operand A to SM
mul_multiplier  out  WIDTH  operand B to SM
mul_product  in  2*WIDTH  SM product
mul_ready  in  1  SM done (level)

Behaviour:
- Reset (async, high): state=IDLE, rr_ptr=0, timeout counter=0. All outputs 0: req_ready, rsp_*, mul_start, operand regs. Asserting reset mid-operation drops the in-flight operation with no response. The SM itself is not reset by this block.
- States: IDLE -> START -> ARM -> WAIT -> RESP -> IDLE.
- IDLE: grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[grant]=1 combinationally in IDLE only; all other bits are 0.
- On handshake (req_valid&req_ready): latch req_a[grant], req_b[grant] into the operand regs and grant into cur_id; go to START.
- START: mul_start=1 for exactly one cycle; go to ARM.
- Operand outputs come from the registers and hold stable from START until the next accept.
- ARM: mul_ready is ignored for one cycle, to mask a stale ready left over from the previous operation. Clear the timeout counter; go to WAIT.
- WAIT: if mul_ready=1, register mul_product into rsp_product with rsp_error=0 and go to RESP. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with mul_ready still 0, set rsp_product=0, rsp_error=1 and go to RESP. If mul_ready and the timeout coincide, ready wins.
- RESP: rsp_valid=1 and rsp_id=cur_id. rsp_product, rsp_id and rsp_error are held stable until rsp_ready=1. On rsp_valid&rsp_ready: rsp_valid falls on the next edge, rr_ptr=(cur_id+1) mod NUM_REQ, go to IDLE.
- No new request is accepted during START/ARM/WAIT/RESP.
- Latency: accept at edge 0 -> mul_start high cycle 1 -> ARM cycle 2 -> earliest capture on cycle 3 -> rsp_valid earliest cycle 4.
- Peak throughput: one op per (SM latency + 4) cycles with rsp_ready tied high.
- Fairness: a requester holding valid continuously is served within NUM_REQ grants.
- Widths: the product is passed through unmodified, 2*WIDTH bits, no truncation or sign handling (unsigned).
- rsp_id wraps mod NUM_REQ. NUM_REQ not a power of 2: rr_ptr wraps explicitly at NUM_REQ-1 -> 0.

Test Plan:
- Single request: req 2 valid, a=16'h0003, b=16'h0005, SM model done after 17 cycles -> req_ready[2] for one cycle; one mul_start pulse; rsp_valid, rsp_id=2, rsp_product=32'h0000000F, rsp_error=0.
- All four requesters valid from reset, rsp_ready=1 -> grant order 0,1,2,3,0. Each product matches a*b, e.g. 16'hFFFF*16'hFFFF=32'hFFFE0001.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable; req_ready all 0; no mul_start. Releasing rsp_ready -> returns to IDLE and serves the next requester.
- Stale ready: SM model keeps mul_ready=1 after the previous op and drops it only on the cycle after start -> the product is captured from the new op, not the stale one.
- Timeout: SM model never asserts ready, TIMEOUT=64 -> rsp_error=1, rsp_product=0 exactly 64 WAIT cycles after ARM. The next request is then served normally.
- Reset mid-WAIT: assert reset -> all outputs 0 asynchronously; no response for the dropped op. After release, req 1 is granted first when both req 1 and req 3 are valid (rr_ptr=0).
